bp_train_queue: RTL and testbench
=================================

# bp_train_queue

Decoupling FIFO between the branch control buffer's commit-side predictor-update output and the branch predictor's training port. Each entry records one committed control-flow instruction (PC, resolved target, direction, mispredict flag). Committed records must reach the predictor even across a backend flush, so the queue is cleared only by reset. Two wrap-around event counters on the output side feed the performance monitors.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥ 2
- PC_W, 32, PC/target width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous and active-high
- in_valid  in  1  control buffer offers a committed branch record
- in_ready  out  1  queue accepts the record this cycle
- in_pc  in  PC_W  branch PC
- in_target  in  PC_W  resolved target
- in_taken  in  1  resolved direction
- in_is_cond  in  1  conditional branch (0 = jump/jal/jalr)
- in_mispred  in  1  prediction was wrong
- out_valid  out  1  head record available
- out_ready  in  1  predictor consumes the head this cycle
- out_pc, out_target  out  PC_W  head fields
- out_taken, out_is_cond, out_mispred  out  1  head fields
- count  out  $clog2(DEPTH)+1  current occupancy
- perf_br_cnt  out  32  records popped
- perf_mispred_cnt  out  32  popped records with mispred = 1

## Operation
- Storage: circular buffer of DEPTH entries; head/tail pointers $clog2(DEPTH)+1 bits wide, with the extra wrap bit.
  - empty = (head == tail).
  - full = index bits equal and wrap bits differ.
- Push: in_valid && in_ready writes at tail, tail += 1.
- Pop: out_valid && out_ready increments head.
- in_ready = !full. It does not depend on out_ready: no pass-through when full.
- out_valid = !empty. The out_* fields are the head entry, driven combinationally from the storage array.
- Simultaneous push and pop:
  - When neither full nor empty: both occur; count unchanged.
  - When empty: only the push occurs, because out_valid = 0.
  - When full: only the pop occurs, because in_ready = 0.
- No bypass: a record pushed in cycle N is first visible on out_* in cycle N+1.
- Pointer wrap: the index wraps modulo DEPTH and the wrap bit toggles. Ordering is strictly FIFO.
- count = tail − head, modulo 2^(ptr width). Range 0..DEPTH.
- Perf counters (performance monitoring only; never saturate):
  - perf_br_cnt += 1 on every pop.
  - perf_mispred_cnt += 1 on a pop whose out_mispred = 1.
  - Both wrap modulo 2^32.
- There is no flush input. The queue holds commit-side state and is cleared only by rst.
- Illegal stimulus is not corrected: in_valid with in_ready = 0 is simply not accepted. The producer holds the record and fields stable until accepted.

## Timing
- Reset (async assert, async apply):
  - head = tail = 0; count = 0.
  - out_valid = 0; in_ready = 1.
  - perf counters = 0.
  - Storage contents are don't-care; out_* data is undefined while out_valid = 0.
- Reset mid-operation: all stored records are discarded immediately, and any handshake in the reset cycle is ignored. First accept is possible on the first clk edge after rst deasserts.
- Latency: push → out_valid 1 cycle. Pop → next entry visible the same cycle the pop registers, i.e. the cycle after the pop handshake.
- Throughput: 1 push and 1 pop per cycle sustained.
- Outputs in_ready, out_valid and count are functions of registered state only; there are no combinational in→out paths.

## Test plan
- Reset then idle: assert rst mid-cycle (async) → in_ready = 1, out_valid = 0, count = 0, perf counters = 0 before the next clk edge.
- Single record: push pc = 0x0000_1000, target = 0x0000_1040, taken = 1, mispred = 1 in cycle 0 →
  - out_valid = 1 in cycle 1 with identical fields.
  - Pop in cycle 1 → count = 0, perf_br_cnt = 1, perf_mispred_cnt = 1 in cycle 2.
- Fill and backpressure, DEPTH = 8, out_ready = 0, push 9 records with pc = 0x100·i →
  - in_ready drops after the 8th push; count = 8; the 9th is held by the producer.
  - Raise out_ready for one cycle → pc 0x000 pops; the 9th is accepted the next cycle.
- Simultaneous push/pop at count = 3 for 20 cycles → count stays 3. Output order equals input order across ≥ 2 pointer wraps.
- Empty push+pop: count = 0, in_valid = 1, out_ready = 1 → push only; count = 1; perf_br_cnt unchanged.
- Reset with 5 records queued → count = 0 and out_valid = 0 immediately. Earlier records never appear after reset release.

Source files
------------

// File: rtl/bp_train_queue.sv
// Commit-side branch training FIFO: decouples predictor-update records from the
// predictor's training port and counts popped branches and mispredicts.
module bp_train_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [PC_W-1:0]          in_target,
  input  logic                     in_taken,
  input  logic                     in_is_cond,
  input  logic                     in_mispred,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [PC_W-1:0]          out_target,
  output logic                     out_taken,
  output logic                     out_is_cond,
  output logic                     out_mispred,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              perf_br_cnt,
  output logic [31:0]              perf_mispred_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PC_W-1:0]  pc_mem_r     [DEPTH];
  logic [PC_W-1:0]  target_mem_r [DEPTH];
  logic [DEPTH-1:0] taken_mem_r;
  logic [DEPTH-1:0] is_cond_mem_r;
  logic [DEPTH-1:0] mispred_mem_r;

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [31:0]      perf_br_r;
  logic [31:0]      perf_mispred_r;

  logic [IDX_W-1:0] head_idx_s;
  logic [IDX_W-1:0] tail_idx_s;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;

  // Pointer MSB is the wrap bit: equal indices with differing wrap bits means full.
  assign head_idx_s = head_r[IDX_W-1:0];
  assign tail_idx_s = tail_r[IDX_W-1:0];
  assign empty_s    = (head_r == tail_r);
  assign full_s     = (head_idx_s == tail_idx_s) && (head_r[IDX_W] != tail_r[IDX_W]);
  assign push_s     = in_valid && !full_s;
  assign pop_s      = !empty_s && out_ready;

  assign in_ready         = !full_s;
  assign out_valid        = !empty_s;
  assign count            = tail_r - head_r;
  assign perf_br_cnt      = perf_br_r;
  assign perf_mispred_cnt = perf_mispred_r;

  assign out_pc      = pc_mem_r[head_idx_s];
  assign out_target  = target_mem_r[head_idx_s];
  assign out_taken   = taken_mem_r[head_idx_s];
  assign out_is_cond = is_cond_mem_r[head_idx_s];
  assign out_mispred = mispred_mem_r[head_idx_s];

  // Record storage; contents only matter where the pointers say they are live.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[tail_idx_s]      <= in_pc;
      target_mem_r[tail_idx_s]  <= in_target;
      taken_mem_r[tail_idx_s]   <= in_taken;
      is_cond_mem_r[tail_idx_s] <= in_is_cond;
      mispred_mem_r[tail_idx_s] <= in_mispred;
    end
  end

  // Pointers and wrapping performance counters; only reset clears the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r         <= {PTR_W{1'b0}};
      tail_r         <= {PTR_W{1'b0}};
      perf_br_r      <= 32'd0;
      perf_mispred_r <= 32'd0;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r    <= head_r + PTR_W'(1);
        perf_br_r <= perf_br_r + 32'd1;
        if (out_mispred) begin
          perf_mispred_r <= perf_mispred_r + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_train_queue.sv
// Scoreboard bench for bp_train_queue: accepted records are queued as expectations
// and compared in order when the predictor side pops them.
module tb_bp_train_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        is_cond;
    logic        mispred;
  } rec_t;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [PC_W-1:0]        in_pc;
  logic [PC_W-1:0]        in_target;
  logic                   in_taken;
  logic                   in_is_cond;
  logic                   in_mispred;
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_W-1:0]        out_pc;
  logic [PC_W-1:0]        out_target;
  logic                   out_taken;
  logic                   out_is_cond;
  logic                   out_mispred;
  logic [$clog2(DEPTH):0] count;
  logic [31:0]            perf_br_cnt;
  logic [31:0]            perf_mispred_cnt;

  rec_t        sb[$];
  int          vectors;
  int          miscompares;
  logic [31:0] exp_br;
  logic [31:0] exp_mis;
  bit          popped;
  rec_t        got;
  rec_t        exp;

  bp_train_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_target(in_target), .in_taken(in_taken),
    .in_is_cond(in_is_cond), .in_mispred(in_mispred),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_target(out_target), .out_taken(out_taken),
    .out_is_cond(out_is_cond), .out_mispred(out_mispred),
    .count(count), .perf_br_cnt(perf_br_cnt), .perf_mispred_cnt(perf_mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic rec_t mk_rec(input logic [31:0] pc);
    rec_t r;
    r.pc      = pc;
    r.target  = $urandom();
    r.taken   = 1'($urandom_range(0, 1));
    r.is_cond = 1'($urandom_range(0, 1));
    r.mispred = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic drive(input rec_t r);
    in_valid   = 1'b1;
    in_pc      = r.pc;
    in_target  = r.target;
    in_taken   = r.taken;
    in_is_cond = r.is_cond;
    in_mispred = r.mispred;
  endtask

  // One clock: record handshakes at the negedge, return #1 after the next posedge.
  task automatic step();
    @(negedge clk);
    popped = out_valid && out_ready && !rst;
    got    = {out_pc, out_target, out_taken, out_is_cond, out_mispred};
    if (in_valid && in_ready && !rst)
      sb.push_back({in_pc, in_target, in_taken, in_is_cond, in_mispred});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(mk_rec(32'h0000_0500)); out_ready = 1'b0; step();
    drive(mk_rec(32'h0000_0504)); step();
    in_valid = 1'b0; out_ready = 1'b1; step();
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d required 0", count); end
    vectors++; if (perf_br_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_perf_br: got %0d required 0", perf_br_cnt); end
    vectors++; if (perf_mispred_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_perf_mis: got %0d required 0", perf_mispred_cnt); end
    sb.delete(); exp_br = 32'd0; exp_mis = 32'd0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    rec_t r;
    r.pc = 32'h0000_1000; r.target = 32'h0000_1040;
    r.taken = 1'b1; r.is_cond = 1'b1; r.mispred = 1'b1;
    out_ready = 1'b0; drive(r); step(); in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b required 1", out_valid); end
    vectors++; if ({out_pc, out_target, out_taken, out_is_cond, out_mispred} !== r)
      begin miscompares++; $display("FAIL single_fields: got pc=%h tgt=%h required pc=%h tgt=%h", out_pc, out_target, r.pc, r.target); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    vectors++;
    if (!popped || sb.size() == 0) begin miscompares++; $display("FAIL single_pop: got popped=%b required 1", popped); end
    else begin
      exp = sb.pop_front(); exp_br++; if (exp.mispred) exp_mis++;
      if (got !== exp) begin miscompares++; $display("FAIL single_order: got pc=%h required pc=%h", got.pc, exp.pc); end
    end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL single_count: got %0d required 0", count); end
    vectors++; if (perf_br_cnt !== 32'd1) begin miscompares++; $display("FAIL single_perf_br: got %0d required 1", perf_br_cnt); end
    vectors++; if (perf_mispred_cnt !== 32'd1) begin miscompares++; $display("FAIL single_perf_mis: got %0d required 1", perf_mispred_cnt); end
  endtask

  task automatic test_fill_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_%0d: got %b required 1", i, in_ready); end
      drive(mk_rec(32'h100 * i)); step();
    end
    drive(mk_rec(32'h100 * DEPTH));
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full_ready: got %b required 0", in_ready); end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL fill_count: got %0d required 8", count); end
    step();
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL fill_held_count: got %0d required 8", count); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    vectors++;
    if (!popped || sb.size() == 0) begin miscompares++; $display("FAIL fill_first_pop: got popped=%b required 1", popped); end
    else begin
      exp = sb.pop_front(); exp_br++; if (exp.mispred) exp_mis++;
      if (got !== exp || got.pc !== 32'h0) begin miscompares++; $display("FAIL fill_first_order: got pc=%h required pc=%h", got.pc, exp.pc); end
    end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_after_pop: got %b required 1", in_ready); end
    step(); in_valid = 1'b0;
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL fill_ninth_count: got %0d required 8", count); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      vectors++;
      if (!popped || sb.size() == 0) begin miscompares++; $display("FAIL fill_drain_%0d: got popped=%b required 1", i, popped); end
      else begin
        exp = sb.pop_front(); exp_br++; if (exp.mispred) exp_mis++;
        if (got !== exp) begin miscompares++; $display("FAIL fill_drain_order: got pc=%h required pc=%h", got.pc, exp.pc); end
      end
    end
    out_ready = 1'b0;
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL fill_drained_count: got %0d required 0", count); end
    vectors++; if (perf_br_cnt !== exp_br) begin miscompares++; $display("FAIL fill_perf_br: got %0d required %0d", perf_br_cnt, exp_br); end
    vectors++; if (perf_mispred_cnt !== exp_mis) begin miscompares++; $display("FAIL fill_perf_mis: got %0d required %0d", perf_mispred_cnt, exp_mis); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(mk_rec(32'h2000 + 32'(i) * 32'd4)); step(); end
    out_ready = 1'b1;
    for (int i = 3; i < 23; i++) begin
      drive(mk_rec(32'h2000 + 32'(i) * 32'd4)); step();
      vectors++;
      if (!popped || sb.size() == 0) begin miscompares++; $display("FAIL b2b_pop_%0d: got popped=%b required 1", i, popped); end
      else begin
        exp = sb.pop_front(); exp_br++; if (exp.mispred) exp_mis++;
        if (got !== exp) begin miscompares++; $display("FAIL b2b_order: got pc=%h required pc=%h", got.pc, exp.pc); end
      end
      vectors++; if (count !== 4'd3) begin miscompares++; $display("FAIL b2b_count_%0d: got %0d required 3", i, count); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (!popped || sb.size() == 0) begin miscompares++; $display("FAIL b2b_drain_%0d: got popped=%b required 1", i, popped); end
      else begin
        exp = sb.pop_front(); exp_br++; if (exp.mispred) exp_mis++;
        if (got !== exp) begin miscompares++; $display("FAIL b2b_drain_order: got pc=%h required pc=%h", got.pc, exp.pc); end
      end
    end
    out_ready = 1'b0;
    vectors++; if (perf_br_cnt !== exp_br) begin miscompares++; $display("FAIL b2b_perf_br: got %0d required %0d", perf_br_cnt, exp_br); end
    vectors++; if (perf_mispred_cnt !== exp_mis) begin miscompares++; $display("FAIL b2b_perf_mis: got %0d required %0d", perf_mispred_cnt, exp_mis); end
  endtask

  task automatic test_empty_push_pop();
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL empty_start_count: got %0d required 0", count); end
    drive(mk_rec(32'h0000_3000)); out_ready = 1'b1; step(); in_valid = 1'b0; out_ready = 1'b0;
    vectors++; if (popped !== 1'b0) begin miscompares++; $display("FAIL empty_no_pop: got %b required 0", popped); end
    vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL empty_count: got %0d required 1", count); end
    vectors++; if (perf_br_cnt !== exp_br) begin miscompares++; $display("FAIL empty_perf_br: got %0d required %0d", perf_br_cnt, exp_br); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    vectors++;
    if (!popped || sb.size() == 0) begin miscompares++; $display("FAIL empty_late_pop: got popped=%b required 1", popped); end
    else begin
      exp = sb.pop_front(); exp_br++; if (exp.mispred) exp_mis++;
      if (got !== exp) begin miscompares++; $display("FAIL empty_order: got pc=%h required pc=%h", got.pc, exp.pc); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(mk_rec(32'h4000 + 32'(i))); step(); end
    in_valid = 1'b0;
    vectors++; if (count !== 4'd5) begin miscompares++; $display("FAIL rmid_count5: got %0d required 5", count); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL rmid_count: got %0d required 0", count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_out_valid: got %b required 0", out_valid); end
    vectors++; if (perf_br_cnt !== 32'd0) begin miscompares++; $display("FAIL rmid_perf_br: got %0d required 0", perf_br_cnt); end
    sb.delete(); exp_br = 32'd0; exp_mis = 32'd0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_ghost_%0d: got out_valid=%b required 0", i, out_valid); end
    end
    out_ready = 1'b0;
    drive(mk_rec(32'h0000_5000)); step(); in_valid = 1'b0;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    vectors++;
    if (!popped || sb.size() == 0) begin miscompares++; $display("FAIL rmid_pop: got popped=%b required 1", popped); end
    else begin
      exp = sb.pop_front(); exp_br++; if (exp.mispred) exp_mis++;
      if (got !== exp) begin miscompares++; $display("FAIL rmid_order: got pc=%h required pc=%h", got.pc, exp.pc); end
    end
    vectors++; if (perf_br_cnt !== 32'd1) begin miscompares++; $display("FAIL rmid_perf_br_after: got %0d required 1", perf_br_cnt); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    in_valid = 1'b0; in_pc = 32'd0; in_target = 32'd0;
    in_taken = 1'b0; in_is_cond = 1'b0; in_mispred = 1'b0; out_ready = 1'b0;
    vectors = 0; miscompares = 0; exp_br = 32'd0; exp_mis = 32'd0;
    popped = 1'b0; got = '0; exp = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_fill_backpressure();
    test_back_to_back();
    test_empty_push_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
